edu_tpu_wb: RTL



---
 rtl/edu_tpu_pkg.sv | 27 ++
 rtl/edu_tpu_wb_if.sv | 23 ++
 rtl/tpu_pe.sv | 55 +++++
 rtl/edu_tpu_wb.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/edu_tpu_pkg.sv
// Shared constants for the Wishbone systolic TPU: register offsets, FSM states,
// STATUS bit positions and the RUN length of an N x N array.
package edu_tpu_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_WEIGHT = 8'h08;
  localparam logic [7:0] OFF_INPUT  = 8'h0C;
  localparam logic [7:0] OFF_RESULT = 8'h40;

  localparam int STS_BUSY = 0;
  localparam int STS_DONE = 1;
  localparam int STS_ERR  = 2;
  localparam int STS_SAT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // skew-in (N-1) + propagate (N) + drain (N)
  function automatic int run_len(input int n);
    return 3 * n - 1;
  endfunction

endpackage

// File: rtl/edu_tpu_wb_if.sv
// Caravel Wishbone slave bundle (everything except clock and reset).
interface edu_tpu_wb_if;
  logic        caravel_wb_stb_i;
  logic        caravel_wb_cyc_i;
  logic        caravel_wb_we_i;
  logic [3:0]  caravel_wb_sel_i;
  logic [31:0] caravel_wb_dat_i;
  logic [31:0] caravel_wb_adr_i;
  logic        caravel_wb_ack_o;
  logic [31:0] caravel_wb_dat_o;

  modport master (
    output caravel_wb_stb_i, caravel_wb_cyc_i, caravel_wb_we_i,
           caravel_wb_sel_i, caravel_wb_dat_i, caravel_wb_adr_i,
    input  caravel_wb_ack_o, caravel_wb_dat_o
  );

  modport slave (
    input  caravel_wb_stb_i, caravel_wb_cyc_i, caravel_wb_we_i,
           caravel_wb_sel_i, caravel_wb_dat_i, caravel_wb_adr_i,
    output caravel_wb_ack_o, caravel_wb_dat_o
  );
endinterface

// File: rtl/tpu_pe.sv
// Weight-stationary MAC cell: holds one weight, passes the input rightwards and
// the partial sum downwards. EDU_TPU_SAT_EN selects clamping instead of wrap.
module tpu_pe #(
  parameter int DW   = 8,
  parameter int ACCW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            w_we_i,
  input  logic [DW-1:0]   w_i,
  input  logic [DW-1:0]   a_i,
  input  logic [ACCW-1:0] psum_i,
  output logic [DW-1:0]   a_o,
  output logic [ACCW-1:0] psum_o,
  output logic [ACCW-1:0] sum_o,
  output logic            sat_o
);
  logic [DW-1:0]   w_q, a_q;
  logic [ACCW-1:0] psum_q;
  logic [2*DW-1:0] prod;

  assign prod = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, w_q};

`ifdef EDU_TPU_SAT_EN
  logic [ACCW:0] wide;
  assign wide  = {1'b0, psum_i} + (ACCW+1)'(prod);
  assign sum_o = wide[ACCW] ? '1 : wide[ACCW-1:0];
  assign sat_o = wide[ACCW];
`else
  assign sum_o = psum_i + ACCW'(prod);
  assign sat_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_q    <= '0;
      a_q    <= '0;
      psum_q <= '0;
    end else begin
      if (w_we_i) w_q <= w_i;
      if (clr_i) begin
        a_q    <= '0;
        psum_q <= '0;
      end else if (en_i) begin
        a_q    <= a_i;
        psum_q <= sum_o;
      end
    end
  end

  assign a_o    = a_q;
  assign psum_o = psum_q;
endmodule

// File: rtl/edu_tpu_wb.sv
// Wishbone-mapped ARRAY_N x ARRAY_N weight-stationary systolic array computing C = A x W.
// Optional EDU_TPU_SAT_EN macro: saturating accumulation plus STATUS SAT flag.
module edu_tpu_wb
  import edu_tpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          ARRAY_N      = 3,
  parameter int          DW           = 8,
  parameter int          ACCW         = 16
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_i,
  edu_tpu_wb_if.slave wb,
  output logic        irq_o
);
  localparam int NN      = ARRAY_N * ARRAY_N;
  localparam int RUN_LEN = run_len(ARRAY_N);
  localparam int CW      = 5;

  state_e          state_q;
  logic            ack_q, irq_q, hold_q, err_q, sat_q;
  logic [31:0]     dat_q, adr_q, rdata, status;
  logic [4:0]      wcnt_q;
  logic [2:0]      rcnt_q;
  logic [CW-1:0]   run_cnt_q;
  logic [DW-1:0]   a_q     [ARRAY_N][ARRAY_N];
  logic [ACCW-1:0] stage_q [ARRAY_N][ARRAY_N];
  logic [ACCW-1:0] res_q   [NN];

  logic            req, fire, wr, ctrl_wr, do_clear, start_req, start_ok, err_set;
  logic            wgt_wr, wgt_ok, in_wr, in_ok, sat_any, unused_bits;
  logic [7:0]      off;
  int              run_t;

  logic [DW-1:0]   feed  [ARRAY_N];
  logic [DW-1:0]   a_h   [ARRAY_N][ARRAY_N+1];
  logic [ACCW-1:0] ps_v  [ARRAY_N+1][ARRAY_N];
  logic [ACCW-1:0] sum_w [ARRAY_N][ARRAY_N];
  logic            sat_w [ARRAY_N][ARRAY_N];

  // a held strobe on the same address is the request already served
  assign req  = wb.caravel_wb_stb_i && wb.caravel_wb_cyc_i &&
                (wb.caravel_wb_adr_i[31:8] == BASE_ADDRESS[31:8]);
  assign fire = req && !(hold_q && (wb.caravel_wb_adr_i == adr_q));
  assign off  = {wb.caravel_wb_adr_i[7:2], 2'b00};
  assign wr   = fire && wb.caravel_wb_we_i;

  assign ctrl_wr   = wr && (off == OFF_CTRL);
  assign do_clear  = ctrl_wr && wb.caravel_wb_dat_i[1];
  assign start_req = ctrl_wr && wb.caravel_wb_dat_i[0] && !wb.caravel_wb_dat_i[1];
  assign start_ok  = start_req && ((state_q == ST_DONE) ||
                     (state_q == ST_IDLE && wcnt_q == 5'(NN) && rcnt_q == 3'(ARRAY_N)));
  assign wgt_wr    = wr && (off == OFF_WEIGHT);
  assign wgt_ok    = wgt_wr && (state_q == ST_IDLE) && (wcnt_q != 5'(NN));
  assign in_wr     = wr && (off == OFF_INPUT);
  assign in_ok     = in_wr && (state_q == ST_IDLE) && (rcnt_q != 3'(ARRAY_N));
  assign err_set   = (start_req && !start_ok) || (wgt_wr && !wgt_ok) || (in_wr && !in_ok);
  assign run_t     = RUN_LEN - 1 - int'(run_cnt_q);

  always_comb begin
    status = '0;
    status[STS_BUSY] = (state_q == ST_RUN);
    status[STS_DONE] = (state_q == ST_DONE);
    status[STS_ERR]  = err_q;
    status[STS_SAT]  = sat_q;
    status[11:8]     = wcnt_q[3:0];
    status[19:16]    = {1'b0, rcnt_q};
    rdata = '0;
    if (off == OFF_STATUS) rdata = status;
    for (int k = 0; k < NN; k++)
      if (off == OFF_RESULT + 8'(4 * k)) rdata = 32'(res_q[k]);
  end

  // row k of the array sees column k of A, delayed k cycles
  always_comb begin
    for (int k = 0; k < ARRAY_N; k++) begin
      feed[k] = '0;
      for (int r = 0; r < ARRAY_N; r++)
        if (run_t == r + k) feed[k] = a_q[r][k];
    end
  end

  for (genvar k = 0; k < ARRAY_N; k++) begin : g_row
    assign a_h[k][0] = feed[k];
    for (genvar c = 0; c < ARRAY_N; c++) begin : g_col
      if (k == 0) begin : g_top
        assign ps_v[0][c] = '0;
      end
      tpu_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .clk_i  (caravel_wb_clk_i),
        .rst_i  (caravel_wb_rst_i),
        .clr_i  (start_ok),
        .en_i   (state_q == ST_RUN),
        .w_we_i (wgt_ok && (wcnt_q == 5'(k * ARRAY_N + c))),
        .w_i    (wb.caravel_wb_dat_i[DW-1:0]),
        .a_i    (a_h[k][c]),
        .psum_i (ps_v[k][c]),
        .a_o    (a_h[k][c+1]),
        .psum_o (ps_v[k+1][c]),
        .sum_o  (sum_w[k][c]),
        .sat_o  (sat_w[k][c])
      );
    end
  end

  always_comb begin
    sat_any     = 1'b0;
    unused_bits = ^{wb.caravel_wb_sel_i, wb.caravel_wb_adr_i[1:0], wb.caravel_wb_dat_i};
    for (int k = 0; k < ARRAY_N; k++) begin
      unused_bits = unused_bits ^ (^a_h[k][ARRAY_N]) ^ (^ps_v[ARRAY_N][k]);
      for (int c = 0; c < ARRAY_N; c++) begin
        sat_any     = sat_any | sat_w[k][c];
        unused_bits = unused_bits ^ (^sum_w[k][c]);
      end
    end
  end

  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
      hold_q    <= 1'b0;
      err_q     <= 1'b0;
      sat_q     <= 1'b0;
      dat_q     <= '0;
      adr_q     <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      run_cnt_q <= '0;
      for (int r = 0; r < ARRAY_N; r++)
        for (int c = 0; c < ARRAY_N; c++) begin
          a_q[r][c]     <= '0;
          stage_q[r][c] <= '0;
        end
      for (int k = 0; k < NN; k++) res_q[k] <= '0;
    end else begin
      ack_q  <= fire;
      dat_q  <= (fire && !wb.caravel_wb_we_i) ? rdata : '0;
      hold_q <= req && (hold_q || fire);
      if (fire) adr_q <= wb.caravel_wb_adr_i;
      if (err_set) err_q <= 1'b1;
      if (wgt_ok) wcnt_q <= wcnt_q + 5'd1;
      if (in_ok) begin
        rcnt_q <= rcnt_q + 3'd1;
        for (int r = 0; r < ARRAY_N; r++)
          for (int j = 0; j < ARRAY_N; j++)
            if (rcnt_q == 3'(r)) a_q[r][j] <= wb.caravel_wb_dat_i[j*DW +: DW];
      end
      if (state_q == ST_RUN) begin
        if (sat_any) sat_q <= 1'b1;
        // C[r][c] leaves the bottom row at run cycle r + c + N - 1
        for (int r = 0; r < ARRAY_N; r++)
          for (int c = 0; c < ARRAY_N; c++)
            if (run_t == r + c + ARRAY_N - 1) stage_q[r][c] <= sum_w[ARRAY_N-1][c];
        if (run_cnt_q == '0) begin
          state_q <= ST_DONE;
          irq_q   <= 1'b1;
          if (!do_clear)
            for (int r = 0; r < ARRAY_N; r++)
              for (int c = 0; c < ARRAY_N; c++) res_q[r*ARRAY_N + c] <= stage_q[r][c];
        end else begin
          run_cnt_q <= run_cnt_q - CW'(1);
        end
      end
      if (start_ok) begin
        state_q   <= ST_RUN;
        irq_q     <= 1'b0;
        run_cnt_q <= CW'(RUN_LEN - 1);
      end
      if (do_clear) begin
        state_q <= ST_IDLE;
        irq_q   <= 1'b0;
        wcnt_q  <= '0;
        rcnt_q  <= '0;
        err_q   <= 1'b0;
        sat_q   <= 1'b0;
      end
    end
  end

  assign wb.caravel_wb_ack_o = ack_q;
  assign wb.caravel_wb_dat_o = dat_q;
  assign irq_o               = irq_q;
endmodule
